// File: rtl/bram_rsp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_rsp_ctrl
// Purpose  : Valid/ready responder for a BRAM port. Reads are tracked through
//            a latency pipeline and their results are buffered in a response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module bram_rsp_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              busy
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] r_pipe;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PW-1:0]    r_wptr;
    logic [c_PW-1:0]    r_rptr;
    logic [c_CW-1:0]    r_count;
    logic [c_CW-1:0]    w_inflight;
    logic [c_CW-1:0]    w_credit;
    logic               w_rd_acc;
    logic               w_push;
    logic               w_pop;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < LATENCY; k++) begin
            w_inflight = w_inflight + c_CW'(r_pipe[k]);
        end
    end

    // Credits cover reads still in the pipeline, so every read owns a FIFO slot.
    assign w_credit   = w_inflight + r_count;
    assign req_ready  = (w_credit < c_CW'(DEPTH));

    assign bram_en    = req_valid & req_ready;
    assign bram_we    = bram_en & req_we;
    assign bram_addr  = req_addr;
    assign bram_wdata = req_wdata;

    assign w_rd_acc   = bram_en & ~req_we;
    assign w_push     = r_pipe[LATENCY-1];
    assign rsp_valid  = (r_count != '0);
    assign w_pop      = rsp_valid & rsp_ready;
    assign rsp_data   = r_mem[r_rptr];
    assign busy       = (w_inflight != '0) | rsp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_acc;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PW'(DEPTH - 1)) ? '0 : r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PW'(DEPTH - 1)) ? '0 : r_rptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bram_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_rsp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_rsp_ctrl
// Purpose  : Self-checking bench for bram_rsp_ctrl with a BRAM model and an
//            outstanding-read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_rsp_ctrl;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              busy;

    int n_checks;
    int n_fail;
    int cyc;

    bram_rsp_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations return a fixed pattern so directed reads have known data.
    function automatic logic [31:0] dflt(input logic [9:0] a);
        return (a == 10'h010) ? 32'hDEADBEEF : 32'hA0 + {22'd0, a};
    endfunction

    logic              mem_clr;
    logic [1023:0]     bm_written;
    logic [31:0]       bm_data [1024];
    logic [31:0]       bm_pipe [LATENCY];

    always @(posedge clk) begin
        if (mem_clr) begin
            bm_written <= '0;
        end else if (bram_en && bram_we) begin
            bm_written[bram_addr] <= 1'b1;
            bm_data[bram_addr]    <= bram_wdata;
        end
        bm_pipe[0] <= bm_written[bram_addr] ? bm_data[bram_addr] : dflt(bram_addr);
        for (int k = 1; k < LATENCY; k++) bm_pipe[k] <= bm_pipe[k-1];
    end
    assign bram_rdata = bm_pipe[LATENCY-1];

    // Reference model: shadow memory plus queue of unpopped reads with visibility cycle.
    typedef struct {
        int          rdy;
        logic [31:0] d;
    } rsp_t;

    rsp_t          q[$];
    logic [1023:0] sh_written;
    logic [31:0]   sh_data [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, input logic rr, output logic acc);
        logic        er;
        logic        ev;
        logic [31:0] rd;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = rr;
        @(negedge clk);
        er = (q.size() < DEPTH);
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        check("req_ready", {31'd0, req_ready}, {31'd0, er});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
        check("busy",      {31'd0, busy},      {31'd0, q.size() > 0});
        check("bram_en",   {31'd0, bram_en},   {31'd0, v & er});
        check("bram_we",   {31'd0, bram_we},   {31'd0, v & er & we});
        check("bram_addr", {22'd0, bram_addr}, {22'd0, a});
        if (v && we) check("bram_wdata", bram_wdata, wd);
        if (ev) check("rsp_data", rsp_data, q[0].d);
        if (ev && rr) void'(q.pop_front());
        acc = v & er;
        if (v && er) begin
            if (we) begin
                sh_written[a] = 1'b1;
                sh_data[a]    = wd;
            end else begin
                rd = sh_written[a] ? sh_data[a] : dflt(a);
                q.push_back('{cyc + LATENCY + 1, rd});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h000, 32'h0, rr, acc);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   k;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        sh_written = '0;
        reset_n    = 1'b0;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        reset_n = 1'b1;
        mem_clr = 1'b0;

        // Single read: response visible only three cycles after acceptance
        step(1'b1, 1'b0, 10'h010, 32'h0, 1'b1, acc);
        idle(5, 1'b1);

        // Fill credits with rsp_ready low, try an extra read, then drain
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'(i), 32'h0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h004, 32'h0, 1'b0, acc);
        idle(6, 1'b1);

        // Write then read back the same word
        step(1'b1, 1'b1, 10'h005, 32'h12345678, 1'b1, acc);
        step(1'b1, 1'b0, 10'h005, 32'h0, 1'b1, acc);
        idle(4, 1'b1);

        // Asynchronous reset with two reads in flight and one entry buffered
        step(1'b1, 1'b0, 10'h001, 32'h0, 1'b0, acc);
        idle(1, 1'b0);
        step(1'b1, 1'b0, 10'h002, 32'h0, 1'b0, acc);
        step(1'b1, 1'b0, 10'h003, 32'h0, 1'b0, acc);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy},      32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        cyc++;
        idle(5, 1'b1);

        // Twelve-read stream with rsp_ready pattern 1,0,0 repeating
        idx = 0;
        k   = 0;
        while (idx < 12 && k < 200) begin
            step(1'b1, 1'b0, 10'h060 + 10'(idx), 32'h0, (k % 3) == 0, acc);
            if (acc) idx++;
            k++;
        end
        check("stream_issued", idx, 12);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 10'h000, 32'h0, (k % 3) == 0, acc);
            k++;
        end

        // Randomized mix of reads, writes and back-pressure
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 4) == 0, 10'($urandom % 32),
                 $urandom, ($urandom % 2) == 0, acc);
        end
        idle(10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
